conv_para_feeder: RTL and testbench
===================================

Name: conv_para_feeder

Overview:
Sequencer on the driving side of the parallel-scale float16 convolution array.
- Fetches the kernel's weights from weight RAM and streams them with matching input vectors into the array, one kernel position per cycle.
- Holds the array in reset between windows.
- Captures the array's result and presents it downstream on a valid/ready handshake.
- Sits between the feature-map/weight buffers and the output writeback path.

Parameters:
PARA_X, 4, MAC groups in the array
PARA_Y, 4, MACs per group
DATA_WIDTH, 16, float16 word width
KERNEL_SIZE_WIDTH, 6, kernel_size port width
KERNEL_SIZE_MAX, 11, largest legal kernel size
W_ADDR_WIDTH, 7, weight RAM address width (≥ ceil(log2(KERNEL_SIZE_MAX²)))
TIMEOUT, 255, max cycles to wait for the array result

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
kernel_size  in  KERNEL_SIZE_WIDTH  k; sampled on start
start  in  1  one-cycle pulse: begin a window (ignored unless IDLE)
busy  out  1  high in any state except IDLE
w_addr  out  W_ADDR_WIDTH  weight RAM read address
w_rdata  in  DATA_WIDTH  weight RAM data, valid 1 cycle after w_addr
in_valid  in  1  input vector valid
in_data  in  PARA_X*PARA_Y*DATA_WIDTH  input vector for current kernel position
in_ready  out  1  input vector accepted this cycle (in_valid & in_ready)
conv_rst_n  out  1  reset to the array, active-low
conv_input_data  out  PARA_X*PARA_Y*DATA_WIDTH  to array input_data
conv_weight  out  DATA_WIDTH  to array weight
conv_kernel_size  out  KERNEL_SIZE_WIDTH  to array kernel_size (latched k)
conv_result_ready  in  1  array result ready
conv_result  in  PARA_X*PARA_Y*DATA_WIDTH  array result_buffer
res_valid  out  1  result valid downstream
res_data  out  PARA_X*PARA_Y*DATA_WIDTH  result word
res_ready  in  1  downstream accept
err  out  2  sticky error flags: bit0 input underflow, bit1 timeout; cleared only by rst

Behaviour:
- Reset values: all outputs 0, except conv_rst_n=0; state IDLE.
- IDLE:
  - conv_rst_n=0, in_ready=0.
  - On start with 1≤k≤KERNEL_SIZE_MAX and res_valid=0: latch k, n=k*k (8-bit product), w_addr=0, go PREFETCH.
  - start with an illegal k (0 or >MAX) is ignored.
  - start while res_valid=1 is ignored; the single result slot must drain first.
- PREFETCH (1 cycle): w_addr=1; go STREAM with idx=0.
- STREAM, one cycle per kernel position idx=0..n-1:
  - conv_rst_n=1, in_ready=1.
  - conv_weight = w_rdata (weight idx); conv_input_data = in_data, registered on the same edge.
  - w_addr advances each cycle (clamped at n-1).
  - If in_valid=0 in any STREAM cycle: set err[0], drop conv_rst_n to 0 next cycle, go IDLE (window aborted, no result).
  - After idx=n-1 is accepted, go WAIT; conv_weight/conv_input_data hold their last values.
- WAIT:
  - conv_rst_n=1, in_ready=0; cycle counter increments.
  - On conv_result_ready=1: capture conv_result into res_data, set res_valid, drive conv_rst_n=0, go IDLE.
  - If the counter reaches TIMEOUT first: set err[1], conv_rst_n=0, go IDLE.
  - conv_result_ready in any state other than WAIT is ignored.
- Output handshake:
  - res_valid holds with res_data stable until res_valid&res_ready; res_valid clears on the following edge.
  - res_ready while res_valid=0 has no effect.
  - busy=0 while a result waits; start is still blocked by res_valid.
- Latency: start → first array data = 2 cycles; window = n cycles plus array latency.
- Minimum start-to-start distance: n+2 cycles plus array wait and result drain.
- Async reset mid-window: immediately drives conv_rst_n=0, clears res_valid, returns to IDLE.

Optional Feature:
CONV_FEED_STATS_EN.
- Defined: adds outputs stat_windows (16 bits, completed windows) and stat_wait_cycles (16 bits, accumulated WAIT cycles). Both saturate, reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- k=3, in_valid held 1, weights 1.0..9.0 (0x3C00…), array responds 10 cycles after release → exactly 9 STREAM cycles, w_addr sequence 0..8, conv_weight sequence matches, res_valid=1 with the captured word, err=0.
- k=1 → single STREAM cycle, w_addr 0 only, result returned, busy drops after capture.
- k=5, in_valid=0 at idx=7 → err=2'b01, conv_rst_n=0 the following cycle, no res_valid, IDLE.
- k=3, array never asserts conv_result_ready → after 255 WAIT cycles err=2'b10, IDLE.
- Result held with res_ready=0 for 20 cycles, start pulsed → start ignored, res_data stable; after res_ready=1, the next start is accepted.
- rst asserted mid-STREAM (idx=4, k=4) → all outputs at reset values immediately; the next start runs a clean window.

Source files
------------

// File: rtl/conv_para_feeder.sv
// conv_para_feeder: drives the parallel-scale float16 convolution array.
// For each window it prefetches weights from the weight RAM, streams one
// (weight, input vector) pair per kernel position into the array, holds the
// array in reset between windows, and hands the captured result downstream
// on a single-slot valid/ready interface.
// Optional build macro CONV_FEED_STATS_EN adds saturating window / wait-cycle
// counters on stat_windows and stat_wait_cycles.
module conv_para_feeder #(
  parameter int PARA_X            = 4,
  parameter int PARA_Y            = 4,
  parameter int DATA_WIDTH        = 16,
  parameter int KERNEL_SIZE_WIDTH = 6,
  parameter int KERNEL_SIZE_MAX   = 11,
  parameter int W_ADDR_WIDTH      = 7,
  parameter int TIMEOUT           = 255
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [KERNEL_SIZE_WIDTH-1:0]         kernel_size,
  input  logic                                 start,
  output logic                                 busy,
  output logic [W_ADDR_WIDTH-1:0]              w_addr,
  input  logic [DATA_WIDTH-1:0]                w_rdata,
  input  logic                                 in_valid,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  in_data,
  output logic                                 in_ready,
  output logic                                 conv_rst_n,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  conv_input_data,
  output logic [DATA_WIDTH-1:0]                conv_weight,
  output logic [KERNEL_SIZE_WIDTH-1:0]         conv_kernel_size,
  input  logic                                 conv_result_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  conv_result,
  output logic                                 res_valid,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  res_data,
  input  logic                                 res_ready,
  output logic [1:0]                           err
`ifdef CONV_FEED_STATS_EN
  ,
  output logic [15:0]                          stat_windows,
  output logic [15:0]                          stat_wait_cycles
`endif
);

  localparam int VEC_W  = PARA_X * PARA_Y * DATA_WIDTH;
  // Kernel position count k*k is an 8-bit quantity (k <= 11 gives 121).
  localparam int CNT_W  = 8;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREFETCH,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [KERNEL_SIZE_WIDTH-1:0] k_q;
  logic [CNT_W-1:0]             n_q;
  logic [CNT_W-1:0]             idx_q;
  logic [WAIT_W-1:0]            wait_cnt_q;

  logic [CNT_W-1:0] n_next;
  logic [CNT_W-1:0] idx_plus2;
  logic [CNT_W-1:0] addr_next;
  logic             k_legal;

  // FSM decode strobes
  logic start_ok;
  logic step_ok;
  logic underflow;
  logic stream_done;
  logic capture;
  logic timeout;

  assign n_next    = CNT_W'(kernel_size) * CNT_W'(kernel_size);
  assign k_legal   = (kernel_size != '0) &&
                     (kernel_size <= KERNEL_SIZE_WIDTH'(KERNEL_SIZE_MAX));
  // While streaming position idx the RAM already holds address idx+1, so the
  // next address to present is idx+2, clamped to the last kernel position.
  assign idx_plus2 = idx_q + CNT_W'(2);
  assign addr_next = (idx_plus2 >= n_q) ? (n_q - CNT_W'(1)) : idx_plus2;

  assign busy             = (state_q != S_IDLE);
  assign in_ready         = (state_q == S_STREAM);
  assign conv_kernel_size = k_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples values from before the edge, regardless of order.
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle decode strobes for the datapath.
  always_comb begin
    // NOTE: every signal gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    state_d     = state_q;
    start_ok    = 1'b0;
    step_ok     = 1'b0;
    underflow   = 1'b0;
    stream_done = 1'b0;
    capture     = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The single result slot must drain before a new window may start.
        if (start && k_legal && !res_valid) begin
          start_ok = 1'b1;
          state_d  = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (!in_valid) begin
          underflow = 1'b1;
          state_d   = S_IDLE;
        end else begin
          step_ok = 1'b1;
          if (idx_q == n_q - CNT_W'(1)) begin
            stream_done = 1'b1;
            state_d     = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A result on the last allowed cycle wins over the timeout.
        if (conv_result_ready) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Window datapath: kernel latch, address sequencing, array feed, result slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these wide datapath registers are reset because they drive
      // ports whose reset value is defined as zero; a pure internal pipeline
      // would normally be left unreset.
      k_q             <= '0;
      n_q             <= '0;
      idx_q           <= '0;
      wait_cnt_q      <= '0;
      w_addr          <= '0;
      conv_rst_n      <= 1'b0;
      conv_weight     <= '0;
      conv_input_data <= '0;
      res_valid       <= 1'b0;
      res_data        <= '0;
      err             <= '0;
    end else begin
      if (start_ok) begin
        k_q    <= kernel_size;
        n_q    <= n_next;
        idx_q  <= '0;
        w_addr <= '0;
      end

      if (state_q == S_PREFETCH) begin
        w_addr <= W_ADDR_WIDTH'((n_q > CNT_W'(1)) ? CNT_W'(1) : CNT_W'(0));
      end

      // Weight and input vector are registered together so the array sees
      // them aligned with its release from reset.
      if (step_ok) begin
        conv_weight     <= w_rdata;
        conv_input_data <= in_data;
        idx_q           <= idx_q + CNT_W'(1);
        w_addr          <= W_ADDR_WIDTH'(addr_next);
      end

      if (stream_done) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_WAIT) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end

      // Array runs only while positions are accepted and while awaiting its
      // result; any abort, capture or timeout puts it back into reset.
      conv_rst_n <= step_ok || ((state_q == S_WAIT) && !capture && !timeout);

      if (capture) begin
        res_data  <= conv_result;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (underflow) err[0] <= 1'b1;
      if (timeout)   err[1] <= 1'b1;
    end
  end

`ifdef CONV_FEED_STATS_EN
  // Saturating counters of completed windows and cycles spent awaiting results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_windows     <= '0;
      stat_wait_cycles <= '0;
    end else begin
      if (capture && (stat_windows != 16'hFFFF)) begin
        stat_windows <= stat_windows + 16'd1;
      end
      if ((state_q == S_WAIT) && (stat_wait_cycles != 16'hFFFF)) begin
        stat_wait_cycles <= stat_wait_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_para_feeder.sv
// Self-checking bench for conv_para_feeder. A behavioural weight RAM and a
// simple array model (result ready a fixed number of cycles after release)
// surround the DUT; expected timing, stream contents, result and error flags
// come from window-level arithmetic in the bench.
module tb_conv_para_feeder;

  localparam int VEC_W = 4 * 4 * 16;
  localparam logic [15:0] FIXED_W [9] = '{16'h3C00, 16'h4000, 16'h4200,
    16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       kernel_size;
  logic             start;
  logic             busy;
  logic [6:0]       w_addr;
  logic [15:0]      w_rdata;
  logic             in_valid;
  logic [VEC_W-1:0] in_data;
  logic             in_ready;
  logic             conv_rst_n;
  logic [VEC_W-1:0] conv_input_data;
  logic [15:0]      conv_weight;
  logic [5:0]       conv_kernel_size;
  logic             conv_result_ready;
  logic [VEC_W-1:0] conv_result;
  logic             res_valid;
  logic [VEC_W-1:0] res_data;
  logic             res_ready;
  logic [1:0]       err;
`ifdef CONV_FEED_STATS_EN
  logic [15:0]      stat_windows;
  logic [15:0]      stat_wait_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0]      weight_mem [128];
  int               arr_cnt;
  int               arr_lat;
  bit               arr_enable;
  logic [VEC_W-1:0] arr_word;

  logic [1:0]       exp_err;
  logic [VEC_W-1:0] last_word;
  int               exp_windows;
  int               exp_wait;

  conv_para_feeder dut (
    .clk               (clk),
    .rst               (rst),
    .kernel_size       (kernel_size),
    .start             (start),
    .busy              (busy),
    .w_addr            (w_addr),
    .w_rdata           (w_rdata),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .conv_rst_n        (conv_rst_n),
    .conv_input_data   (conv_input_data),
    .conv_weight       (conv_weight),
    .conv_kernel_size  (conv_kernel_size),
    .conv_result_ready (conv_result_ready),
    .conv_result       (conv_result),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .res_ready         (res_ready),
`ifdef CONV_FEED_STATS_EN
    .stat_windows      (stat_windows),
    .stat_wait_cycles  (stat_wait_cycles),
`endif
    .err               (err)
  );

  always #5 clk = ~clk;

  // Weight RAM: registered read, data one cycle after the address.
  always_ff @(posedge clk) w_rdata <= weight_mem[w_addr];

  // Array model: counts cycles out of reset, result ready after arr_lat.
  always_ff @(posedge clk) begin
    if (!conv_rst_n) arr_cnt <= 0;
    else             arr_cnt <= arr_cnt + 1;
  end
  assign conv_result_ready = arr_enable && conv_rst_n && (arr_cnt >= arr_lat);
  assign conv_result       = arr_word;

  task automatic check(input string tag, input logic [VEC_W-1:0] got,
                       input logic [VEC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One window from start to return to IDLE. uf_idx >= 0 withholds in_valid
  // at that kernel position. Called and returns just after a falling edge.
  task automatic run_window(input int k, input int lat, input bit respond,
                            input int uf_idx, input bit fixed_w);
    int n, acc, busy_cyc, guard, w, exp_busy;
    bit exp_res;
    logic rst_at_uf;
    logic [15:0]      exp_w[$];
    logic [15:0]      obs_w[$];
    logic [VEC_W-1:0] exp_v[$];
    logic [VEC_W-1:0] obs_v[$];
    n = k * k;
    for (int a = 0; a < 128; a++)
      weight_mem[a] = (fixed_w && a < 9) ? FIXED_W[a] : 16'($urandom);
    arr_word   = rand_vec();
    arr_lat    = lat;
    arr_enable = respond;
    rst_at_uf  = 1'b0;
    kernel_size = 6'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0; busy_cyc = 0; guard = 0;
    while (busy && guard < 1000) begin
      busy_cyc++;
      guard++;
      if (busy_cyc == 1) check("prefetch_addr", w_addr, 0);
      if (conv_rst_n && obs_w.size() < n) begin
        obs_w.push_back(conv_weight);
        obs_v.push_back(conv_input_data);
      end
      in_data = rand_vec();
      if (in_ready && acc == uf_idx) begin
        in_valid  = 1'b0;
        rst_at_uf = conv_rst_n;
      end else begin
        in_valid = 1'b1;
        if (in_ready) begin
          exp_w.push_back(weight_mem[acc]);
          exp_v.push_back(in_data);
          acc++;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("window_bounded", guard < 1000, 1);

    // Window-level expectations.
    exp_res = 1'b0;
    w = 0;
    if (uf_idx >= 0) begin
      exp_busy = 1 + uf_idx + 1;
      exp_err[0] = 1'b1;
      if (uf_idx > 0) check("uf_array_running", rst_at_uf, 1);
    end else begin
      w = (lat - n + 2 > 1) ? lat - n + 2 : 1;
      if (!respond || w > 255) begin
        w = 255;
        exp_err[1] = 1'b1;
      end else begin
        exp_res = 1'b1;
      end
      exp_busy = 1 + n + w;
      exp_wait += w;
    end
    check("busy_cycles", busy_cyc, exp_busy);
    check("conv_rst_n_after", conv_rst_n, 0);
    check("conv_kernel_size", conv_kernel_size, k);
    check("err", err, exp_err);
    check("res_valid", res_valid, exp_res);
    if (exp_res) begin
      check("res_data", res_data, arr_word);
      last_word = arr_word;
      exp_windows++;
    end
    check("stream_len", obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++) begin
      check($sformatf("weight[%0d]", i), obs_w[i], exp_w[i]);
      check($sformatf("vector[%0d]", i), obs_v[i], exp_v[i]);
    end
    if (exp_w.size() > 0) check("weight_hold", conv_weight, exp_w[$]);
  endtask

  // Holds the result for 'hold' cycles (pulsing start once), then drains it.
  task automatic drain(input int hold);
    int bad_stable, bad_busy;
    bad_stable = 0;
    bad_busy   = 0;
    check("drain_valid", res_valid, 1);
    for (int c = 0; c < hold; c++) begin
      start = (c == 1);
      kernel_size = 6'd3;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== last_word) bad_stable++;
      if (busy !== 1'b0) bad_busy++;
    end
    start = 1'b0;
    if (hold > 0) begin
      check("hold_stable", bad_stable, 0);
      check("hold_start_blocked", bad_busy, 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("drain_cleared", res_valid, 0);
    // res_ready without a pending result must have no effect.
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_ready_noop", {res_valid, busy}, 2'b00);
  endtask

  initial begin
    int acc, k, lat;
    rst = 1'b1; start = 1'b0; kernel_size = '0; in_valid = 1'b0;
    in_data = '0; res_ready = 1'b0; arr_enable = 1'b0; arr_lat = 0;
    arr_word = '0; exp_err = '0; exp_windows = 0; exp_wait = 0;
    for (int a = 0; a < 128; a++) weight_mem[a] = '0;
    #2 rst = 1'b0;
    #20;
    check("rst_conv_rst_n", conv_rst_n, 0);
    check("rst_outputs", {busy, in_ready, res_valid, err, w_addr}, 0);
    check("rst_data", {conv_weight, conv_kernel_size, conv_input_data} , 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // k=3, fixed weights 1.0..9.0, array answers 10 cycles after release.
    run_window(3, 10, 1'b1, -1, 1'b1);
    drain(0);

    // k=1: single position.
    run_window(1, 3, 1'b1, -1, 1'b0);
    check("k1_busy_low", busy, 0);
    drain(0);

    // Illegal kernel sizes are ignored.
    foreach (FIXED_W[i]) begin
      if (i < 3) begin
        kernel_size = (i == 0) ? 6'd0 : (i == 1) ? 6'd12 : 6'd63;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check($sformatf("illegal_k_%0d", kernel_size), busy, 0);
      end
    end

    // Result held 20 cycles with start pulsed, then next window accepted.
    run_window(2, 5, 1'b1, -1, 1'b0);
    drain(20);
    run_window(4, 20, 1'b1, -1, 1'b0);
    drain(0);

    // Randomized windows.
    for (int r = 0; r < 6; r++) begin
      k   = $urandom_range(1, 11);
      lat = $urandom_range(0, 40);
      run_window(k, lat, 1'b1, -1, 1'b0);
      drain($urandom_range(0, 3));
    end

    // k=5, input underflow at position 7.
    run_window(5, 10, 1'b1, 7, 1'b0);
    check("uf_err", err, 2'b01);

    // Reset mid-stream at position 4 of k=4.
    kernel_size = 6'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready && acc == 4) break;
      if (in_ready) acc++;
      in_valid = 1'b1;
      in_data = rand_vec();
      @(negedge clk);
    end
    check("rst_mid_reached", {in_ready, acc[2:0]}, {1'b1, 3'd4});
    rst = 1'b0;
    #1;
    check("rst_mid_conv_rst_n", conv_rst_n, 0);
    check("rst_mid_ctrl", {busy, in_ready, res_valid, err, w_addr}, 0);
    check("rst_mid_data", {conv_weight, conv_kernel_size, conv_input_data}, 0);
    exp_err = '0; exp_windows = 0; exp_wait = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_window(4, 18, 1'b1, -1, 1'b0);
    drain(0);

    // Result on the last allowed WAIT cycle is still captured (n=4, w=255).
    run_window(2, 257, 1'b1, -1, 1'b0);
    drain(0);
    check("late_result_err", err, 2'b00);

    // k=3, array never answers: timeout after 255 WAIT cycles.
    run_window(3, 0, 1'b0, -1, 1'b0);
    check("timeout_err", err, 2'b10);

`ifdef CONV_FEED_STATS_EN
    check("stat_windows", stat_windows, exp_windows);
    check("stat_wait_cycles", stat_wait_cycles, exp_wait);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
